an_encoder_24bits: RTL and testbench
====================================

// Module: an_encoder_24bits
// PURPOSE
//  AN-code encoder and error injector for the 24-bit product-code path. Accepts a
//  message N and forms codeword W = A*N with a sequential shift-add multiplier.
//  Optionally adds up to two arithmetic errors of +/-2^(|l|-1). Feeds the
//  trade-off SEC/DEC decoder and its testbenches over a valid/ready handshake.
// PARAMETERS
//  A       13837  AN-code constant (odd; must fit in A_BITS)
//  A_BITS  14     width of A; number of multiply iterations
//  N_BITS  25     message width
//  W_BITS  39     codeword width (A*(2^N_BITS-1) < 2^W_BITS)
//  L_BITS  6      error-location magnitude width; locations are signed L_BITS+1 bits
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         synchronous reset, active high
//  in_valid   in   1         N, err_l1 and err_l2 are valid
//  in_ready   out  1         encoder can accept; high only in IDLE
//  N          in   N_BITS    message
//  err_l1     in   L_BITS+1  signed error location 1; 0 = none
//  err_l2     in   L_BITS+1  signed error location 2; 0 = none
//  out_valid  out  1         W and W_clean are valid
//  out_ready  in   1         downstream accepts the output
//  W          out  W_BITS    codeword with injected errors
//  W_clean    out  W_BITS    error-free codeword A*N
//  cw_cnt     out  16        count of completed output handshakes, wraps at 2^16
// BEHAVIOUR
//  Reset (rst high at a clk edge): state=IDLE; out_valid=0; W=0; W_clean=0;
//   cw_cnt=0; internal acc/cnt cleared. Reset mid-operation aborts the word:
//   no output, and in_ready=1 in the following cycle.
//  in_ready is combinational: in_ready = (state==IDLE).
//  FSM states: IDLE, MUL, INJ, OUT.
//  IDLE: on in_valid & in_ready, latch N, err_l1 and err_l2; acc=0; cnt=0; go to MUL.
//  MUL: on each edge, if A[cnt]==1 then acc += (N_reg << cnt), mod 2^W_BITS.
//   Then cnt++. Go to INJ after the edge with cnt==A_BITS-1.
//   MUL lasts exactly A_BITS cycles.
//  INJ: W_clean <= acc; W <= (acc + e(l1) + e(l2)) mod 2^W_BITS;
//   out_valid <= 1; go to OUT.
//  e(l) definition:
//   - 0 if l==0 or |l| > W_BITS.
//   - +2^(l-1) if l > 0.
//   - -2^(|l|-1) if l < 0, in two's complement at W_BITS width.
//   l = -2^L_BITS is treated as |l| > W_BITS, so e = 0.
//  Duplicate locations: l1==l2 adds 2*2^(l-1); l1==-l2 cancels, so W = W_clean.
//  OUT: W, W_clean and out_valid are held stable until out_ready.
//   On out_valid & out_ready: out_valid <= 0; cw_cnt++; go to IDLE.
//  Latency: with acceptance at edge T, out_valid rises after edge T+A_BITS+1
//   (15 cycles at the defaults). Peak throughput is one word per A_BITS+3 cycles.
//  in_valid is ignored outside IDLE. Inputs are sampled only at acceptance and
//   may change afterwards.
//  out_ready is ignored while out_valid=0.
// TESTING
//  N=5, no errors -> W=W_clean=69185, out_valid 15 cycles after accept, cw_cnt=1
//  N=1000, l1=+3, l2=-14 -> W_clean=13837000, W=13828812
//  N=33554431, l1=+39 -> W_clean=464292661747, W wraps to 189414754803
//  N=7, l1=+5, l2=-5 -> W=W_clean=96859; l1=-64 -> no error added
//  out_ready low for 10 cycles in OUT -> W held; in_ready=0; in_valid pulses ignored
//  rst high during MUL cycle 5 -> out_valid stays 0, in_ready=1 next cycle, cw_cnt=0

Source files
------------

// File: rtl/an_encoder_24bits.sv
// an_encoder_24bits: AN-code shift-add encoder with optional two-error arithmetic injection
module an_encoder_24bits #(
    parameter int A      = 13837,
    parameter int A_BITS = 14,
    parameter int N_BITS = 25,
    parameter int W_BITS = 39,
    parameter int L_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] N,
    input  logic [L_BITS:0]   err_l1,
    input  logic [L_BITS:0]   err_l2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] W,
    output logic [W_BITS-1:0] W_clean,
    output logic [15:0]       cw_cnt
);
    localparam int CW = $clog2(A_BITS);
    localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A);
    localparam logic [CW-1:0] CNT_LAST = CW'(A_BITS - 1);
    localparam logic [L_BITS:0] L_MAX = (L_BITS + 1)'(W_BITS);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] INJ  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;
    logic [1:0]        state;
    logic [N_BITS-1:0] n_reg;
    logic [L_BITS:0]   l1_reg, l2_reg;
    logic [W_BITS-1:0] acc;
    logic [CW-1:0]     cnt;
    function automatic logic [W_BITS-1:0] err(input logic [L_BITS:0] l);
        logic [L_BITS:0]   mag;
        logic [W_BITS-1:0] p;
        mag = l[L_BITS] ? -l : l;
        p = (mag == '0 || mag > L_MAX) ? '0 : W_BITS'(1) << (mag - (L_BITS + 1)'(1));
        return l[L_BITS] ? -p : p;
    endfunction
    assign in_ready = (state == IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_reg     <= '0;
            l1_reg    <= '0;
            l2_reg    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            W         <= '0;
            W_clean   <= '0;
            cw_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    n_reg  <= N;
                    l1_reg <= err_l1;
                    l2_reg <= err_l2;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= MUL;
                end
                MUL: begin
                    if (A_VEC[cnt]) acc <= acc + (W_BITS'(n_reg) << cnt);
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) state <= INJ;
                end
                INJ: begin
                    W_clean   <= acc;
                    W         <= acc + err(l1_reg) + err(l2_reg);
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                default: if (out_ready) begin
                    out_valid <= 1'b0;
                    cw_cnt    <= cw_cnt + 16'd1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_an_encoder_24bits.sv
// tb_an_encoder_24bits: vector table, randomized model check and corner sequences
module tb_an_encoder_24bits;
    logic               clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [24:0]        N;
    logic signed [6:0]  err_l1, err_l2;
    logic [38:0]        W, W_clean;
    logic [15:0]        cw_cnt;
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [24:0]       n;
        logic signed [6:0] l1;
        logic signed [6:0] l2;
        logic [38:0]       w;
        logic [38:0]       wc;
    } vec_t;
    vec_t tbl[10];

    an_encoder_24bits dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .N(N), .err_l1(err_l1), .err_l2(err_l2), .out_valid(out_valid),
        .out_ready(out_ready), .W(W), .W_clean(W_clean), .cw_cnt(cw_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint e_of(input logic signed [6:0] l);
        int m;
        m = (l < 0) ? -int'(l) : int'(l);
        if (l == 0 || m > 39) return 0;
        return (l > 0) ? (longint'(1) << (m - 1)) : -(longint'(1) << (m - 1));
    endfunction

    function automatic logic [38:0] model_w(input logic [24:0] n, input logic signed [6:0] a, input logic signed [6:0] b);
        longint s;
        s = longint'(n) * 13837 + e_of(a) + e_of(b);
        return s[38:0];
    endfunction

    function automatic logic [38:0] model_wc(input logic [24:0] n);
        longint s;
        s = longint'(n) * 13837;
        return s[38:0];
    endfunction

    task automatic do_word(input logic [24:0] n, input logic signed [6:0] a, input logic signed [6:0] b,
                           input logic [38:0] ew, input logic [38:0] ewc, input int hold, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; N = n; err_l1 = a; err_l2 = b;
        @(negedge clk);
        in_valid = 1'b0; N = 25'($urandom); err_l1 = 7'($urandom); err_l2 = 7'($urandom);
        chk({tag, "_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 15);
        chk({tag, "_W"}, W, ew);
        chk({tag, "_W_clean"}, W_clean, ewc);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            N = 25'($urandom);
            @(negedge clk);
            chk({tag, "_hold_W"}, W, ew);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
            chk({tag, "_hold_valid"}, out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_cw_cnt"}, cw_cnt, 16'(exp_cnt));
    endtask

    initial begin
        logic [24:0]       n;
        logic signed [6:0] a, b;
        int stray;
        tbl[0] = '{25'd5,        7'sd0,  7'sd0,   39'd69185,        39'd69185};
        tbl[1] = '{25'd1000,     7'sd3,  -7'sd14, 39'd13828812,     39'd13837000};
        tbl[2] = '{25'd33554431, 7'sd39, 7'sd0,   39'd189414754803, 39'd464292661747};
        tbl[3] = '{25'd7,        7'sd5,  -7'sd5,  39'd96859,        39'd96859};
        tbl[4] = '{25'd7,        -7'sd64, 7'sd0,  39'd96859,        39'd96859};
        tbl[5] = '{25'd0,        7'sd0,  7'sd0,   39'd0,            39'd0};
        tbl[6] = '{25'd1,        7'sd1,  7'sd1,   39'd13839,        39'd13837};
        tbl[7] = '{25'd1,        -7'sd1, 7'sd0,   39'd13836,        39'd13837};
        tbl[8] = '{25'd0,        -7'sd39, 7'sd0,  39'd274877906944, 39'd0};
        tbl[9] = '{25'd0,        7'sd40, 7'sd0,   39'd0,            39'd0};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; N = '0; err_l1 = '0; err_l2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_W", W, 0);
        chk("rst_W_clean", W_clean, 0);
        chk("rst_cw_cnt", cw_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 10; i++)
            do_word(tbl[i].n, tbl[i].l1, tbl[i].l2, tbl[i].w, tbl[i].wc, 0, $sformatf("vec%0d", i));
        do_word(25'd5, 7'sd0, 7'sd0, 39'd69185, 39'd69185, 10, "hold");
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("hold_no_extra_word", stray, 0);
        @(negedge clk);
        in_valid = 1'b1; N = 25'd123; err_l1 = 7'sd0; err_l2 = 7'sd0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_cw_cnt", cw_cnt, 0);
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("abort_no_out", stray, 0);
        for (int i = 0; i < 40; i++) begin
            n = 25'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 7'sd0 : 7'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 7'sd0 : 7'($urandom);
            do_word(n, a, b, model_w(n, a, b), model_wc(n), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
